// File: rtl/lfsr_hex_display.sv
// lfsr_hex_display: snapshots a 16-bit word onto the 4-digit muxed 7-seg display, blinking digit-0 dp on mark.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module lfsr_hex_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int MARK_HOLD   = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        mark,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int MW = MARK_HOLD > 0 ? $clog2(MARK_HOLD + 1) : 1;
  logic [15:0]   snap;
  logic [1:0]    idx;
  logic [RW-1:0] refresh_cnt;
  logic [MW-1:0] mark_cnt;
  logic [3:0]    nib;
  logic [6:0]    hex;
  logic [6:0]    seg_next;
  logic          slot_end;
  always_comb begin
    nib = snap[{idx, 2'b00} +: 4];
    case (nib)
      4'h0: hex = 7'b1000000;
      4'h1: hex = 7'b1111001;
      4'h2: hex = 7'b0100100;
      4'h3: hex = 7'b0110000;
      4'h4: hex = 7'b0011001;
      4'h5: hex = 7'b0010010;
      4'h6: hex = 7'b0000010;
      4'h7: hex = 7'b1111000;
      4'h8: hex = 7'b0000000;
      4'h9: hex = 7'b0010000;
      4'hA: hex = 7'b0001000;
      4'hB: hex = 7'b0000011;
      4'hC: hex = 7'b1000110;
      4'hD: hex = 7'b0100001;
      4'hE: hex = 7'b0000110;
      default: hex = 7'b0001110;
    endcase
  end
`ifdef LEADING_ZERO_BLANK_EN
  logic blank;
  // a digit is blank only when it and every more significant nibble are zero
  always_comb blank = idx == 2'd3 ? snap[15:12] == 4'h0 :
                      idx == 2'd2 ? snap[15:8] == 8'h0 :
                      idx == 2'd1 ? snap[15:4] == 12'h0 : 1'b0;
  always_comb seg_next = blank ? 7'b1111111 : hex;
`else
  always_comb seg_next = hex;
`endif
  always_comb slot_end = refresh_cnt == RW'(REFRESH_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      snap        <= '0;
      idx         <= '0;
      refresh_cnt <= '0;
      mark_cnt    <= '0;
      an          <= 4'b1110;
      seg         <= 7'b1000000;
      dp          <= 1'b1;
    end else begin
      refresh_cnt <= slot_end ? '0 : refresh_cnt + 1'b1;
      idx         <= slot_end ? idx + 2'd1 : idx;
      if (load) snap <= value;
      mark_cnt    <= mark ? MW'(MARK_HOLD) : mark_cnt != '0 ? mark_cnt - 1'b1 : mark_cnt;
      an          <= ~(4'b0001 << idx);
      seg         <= seg_next;
      dp          <= ~(idx == 2'd0 && mark_cnt != '0);
    end
  end
endmodule

// File: tb/tb_lfsr_hex_display.sv
// tb_lfsr_hex_display: randomized self-checking bench against a cycle-count/timestamp reference model.
module tb_lfsr_hex_display;
  localparam int RD = 4;
  localparam int MH = 10;
  logic clk = 0, rst = 1, load = 0, mark = 0;
  logic [15:0] value = '0;
  logic [3:0] an, an0;
  logic [6:0] seg, seg0;
  logic dp, dp0;
  int checks = 0, failures = 0;
  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int cyc = 0, since = 0, last_mark = 0, mi;
  bit has_mark = 0;
  logic [15:0] msnap = '0;
  logic [3:0] exp_an = 4'b1110;
  logic [6:0] exp_seg = 7'b1000000;
  logic exp_dp = 1'b1;

  always #5 clk = ~clk;

  lfsr_hex_display #(.REFRESH_DIV(RD), .MARK_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .mark(mark), .an(an), .seg(seg), .dp(dp));
  lfsr_hex_display #(.REFRESH_DIV(RD), .MARK_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .value(value), .load(load), .mark(mark), .an(an0), .seg(seg0), .dp(dp0));

  // Model: digit = (edges since reset / RD) mod 4; blink = time since last mark pulse below MH.
  always @(posedge clk) begin
    if (rst) begin
      exp_an = 4'b1110;
      exp_seg = hex_tab[0];
      exp_dp = 1'b1;
      since = 0;
      has_mark = 0;
      msnap = '0;
    end else begin
      mi = (since / RD) % 4;
      exp_an = 4'b1111;
      exp_an[mi] = 1'b0;
      exp_seg = hex_tab[int'((msnap >> (4 * mi)) & 16'hf)];
`ifdef LEADING_ZERO_BLANK_EN
      if (mi > 0 && (msnap >> (4 * mi)) == 16'h0) exp_seg = 7'b1111111;
`endif
      exp_dp = !(mi == 0 && has_mark && (cyc - 1 - last_mark) < MH);
      since++;
      if (load) msnap = value;
      if (mark) begin
        has_mark = 1;
        last_mark = cyc;
      end
    end
    cyc++;
  end

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks += 3;
      if (an !== 4'b1110) begin failures++; $display("FAIL reset_an got=%b want=1110", an); end
      if (seg !== 7'b1000000) begin failures++; $display("FAIL reset_seg got=%b want=1000000", seg); end
      if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b want=1", dp); end
    end
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks += 2;
      if (an !== exp_an) begin failures++; $display("FAIL scan_an cyc=%0d got=%b want=%b", cyc, an, exp_an); end
      if (seg !== exp_seg) begin failures++; $display("FAIL scan_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
    end
  endtask

  task automatic test_snapshot();
    value = 16'h0145;
    load = 1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      load = 0;
      checks += 3;
      if (an !== exp_an) begin failures++; $display("FAIL snap_an cyc=%0d got=%b want=%b", cyc, an, exp_an); end
      if (seg !== exp_seg) begin failures++; $display("FAIL snap_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
      if (dp !== exp_dp) begin failures++; $display("FAIL snap_dp cyc=%0d got=%b want=%b", cyc, dp, exp_dp); end
    end
  endtask

  task automatic test_hold();
    value = 16'hABCD;
    load = 1;
    @(negedge clk);
    load = 0;
    value = 16'h1234;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      value = i < 20 ? 16'h1234 : 16'($urandom);
      checks += 2;
      if (an !== exp_an) begin failures++; $display("FAIL hold_an cyc=%0d got=%b want=%b", cyc, an, exp_an); end
      if (seg !== exp_seg) begin failures++; $display("FAIL hold_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
    end
  endtask

  task automatic test_mark();
    mark = 1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      mark = i == 4;
      checks += 2;
      if (dp !== exp_dp) begin failures++; $display("FAIL mark_dp cyc=%0d got=%b want=%b", cyc, dp, exp_dp); end
      if (dp0 !== 1'b1) begin failures++; $display("FAIL mark_hold0_dp cyc=%0d got=%b want=1", cyc, dp0); end
    end
  endtask

  task automatic test_blank();
    for (int p = 0; p < 2; p++) begin
      value = p == 0 ? 16'h0045 : 16'h0000;
      load = 1;
      for (int i = 0; i < 18; i++) begin
        @(negedge clk);
        load = 0;
        checks += 2;
        if (an !== exp_an) begin failures++; $display("FAIL blank_an cyc=%0d got=%b want=%b", cyc, an, exp_an); end
        if (seg !== exp_seg) begin failures++; $display("FAIL blank_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
      end
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    value = 16'h9E7F;
    load = 1;
    @(negedge clk);
    load = 0;
    while (exp_an !== 4'b1011 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin failures++; $display("FAIL midrst_wait got=timeout want=digit2"); end
    mark = 1;
    @(negedge clk);
    mark = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks += 3;
    if (an !== 4'b1110) begin failures++; $display("FAIL midrst_an got=%b want=1110", an); end
    if (seg !== 7'b1000000) begin failures++; $display("FAIL midrst_seg got=%b want=1000000", seg); end
    if (dp !== 1'b1) begin failures++; $display("FAIL midrst_dp got=%b want=1", dp); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks += 3;
      if (an !== exp_an) begin failures++; $display("FAIL post_an cyc=%0d got=%b want=%b", cyc, an, exp_an); end
      if (seg !== exp_seg) begin failures++; $display("FAIL post_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
      if (dp !== exp_dp) begin failures++; $display("FAIL post_dp cyc=%0d got=%b want=%b", cyc, dp, exp_dp); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      checks += 4;
      if (an !== exp_an) begin failures++; $display("FAIL rand_an cyc=%0d got=%b want=%b", cyc, an, exp_an); end
      if (seg !== exp_seg) begin failures++; $display("FAIL rand_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
      if (dp !== exp_dp) begin failures++; $display("FAIL rand_dp cyc=%0d got=%b want=%b", cyc, dp, exp_dp); end
      if (dp0 !== 1'b1) begin failures++; $display("FAIL rand_hold0_dp cyc=%0d got=%b want=1", cyc, dp0); end
      value = $urandom_range(3) == 0 ? 16'($urandom_range(255)) : 16'($urandom);
      load = $urandom_range(7) == 0;
      mark = $urandom_range(15) == 0;
      rst = $urandom_range(99) == 0;
    end
    rst = 0;
    load = 0;
    mark = 0;
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_hold();
    test_mark();
    test_blank();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
